// File: rtl/reg_scoreboard_if.sv
// ID-stage decode bundle in, stall/issue controls and scoreboard status out.
interface reg_scoreboard_if;
    logic        ID_Valid;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic        ID_WriteEn;
    logic [4:0]  ID_rDest;
    logic [1:0]  ID_Class;
    logic        Flush;
    logic        Stall_PC;
    logic        Stall_ID;
    logic        Stall_ID_EX;
    logic        Issue;
    logic [31:0] Pending;
    logic [31:0] StallCycles;

    modport master (
        output ID_Valid, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_WriteEn, ID_rDest, ID_Class, Flush,
        input  Stall_PC, Stall_ID, Stall_ID_EX, Issue, Pending, StallCycles
    );

    modport slave (
        input  ID_Valid, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_WriteEn, ID_rDest, ID_Class, Flush,
        output Stall_PC, Stall_ID, Stall_ID_EX, Issue, Pending, StallCycles
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register countdown scoreboard for ID: a consumer waits exactly Lat cycles after its producer issues.
// Stall/Issue are combinational from current state; stall holds PC and IF/ID and bubbles ID/EX.
module reg_scoreboard #(
    parameter int unsigned CNT_WIDTH = 3,
    parameter int unsigned ALU_LAT   = 2,
    parameter int unsigned LOAD_LAT  = 2,
    parameter int unsigned MUL_LAT   = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    reg_scoreboard_if.slave sb
);
    localparam int unsigned CNT_MAX = (1 << CNT_WIDTH) - 1;

    if (ALU_LAT > CNT_MAX || LOAD_LAT > CNT_MAX || MUL_LAT > CNT_MAX) begin : g_lat_too_wide
        $error("reg_scoreboard: a latency does not fit in CNT_WIDTH bits");
    end

    localparam logic [CNT_WIDTH-1:0] ALU_L  = CNT_WIDTH'(ALU_LAT);
    localparam logic [CNT_WIDTH-1:0] LOAD_L = CNT_WIDTH'(LOAD_LAT);
    localparam logic [CNT_WIDTH-1:0] MUL_L  = CNT_WIDTH'(MUL_LAT);

    logic [CNT_WIDTH-1:0] cnt_q [1:31];
    logic [CNT_WIDTH-1:0] cnt   [32];
    logic [CNT_WIDTH-1:0] lat;
    logic [31:0]          stall_cycles;
    logic [31:0]          pending;
    logic                 raw_rs, raw_rt, waw, hazard, stall, issue, set_en;

    // Register 0 never holds a busy count, so reads of $0 can never hazard.
    always_comb begin
        cnt[0] = '0;
        for (int r = 1; r < 32; r++) cnt[r] = cnt_q[r];
    end

    always_comb begin
        lat = MUL_L;
        case (sb.ID_Class)
            2'd0:    lat = ALU_L;
            2'd1:    lat = LOAD_L;
            default: lat = MUL_L;
        endcase
    end

    // WAW: an older write still further out than this one would retire after it.
    assign raw_rs = sb.ID_UsesRs  && (sb.ID_rs    != 5'd0) && (cnt[sb.ID_rs] != '0);
    assign raw_rt = sb.ID_UsesRt  && (sb.ID_rt    != 5'd0) && (cnt[sb.ID_rt] != '0);
    assign waw    = sb.ID_WriteEn && (sb.ID_rDest != 5'd0) && (cnt[sb.ID_rDest] > lat);
    assign hazard = raw_rs || raw_rt || waw;

    assign stall  = sb.ID_Valid &&  hazard && !sb.Flush;
    assign issue  = sb.ID_Valid && !hazard && !sb.Flush;
    assign set_en = issue && sb.ID_WriteEn && (sb.ID_rDest != 5'd0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
            stall_cycles <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (set_en && (sb.ID_rDest == 5'(r))) begin
                    cnt_q[r] <= lat;
                end else if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - CNT_WIDTH'(1);
                end
            end
            if (stall) stall_cycles <= stall_cycles + 32'd1;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < 32; r++) pending[r] = (cnt[r] != '0);
    end

    assign sb.Stall_PC    = stall;
    assign sb.Stall_ID    = stall;
    assign sb.Stall_ID_EX = stall;
    assign sb.Issue       = issue;
    assign sb.Pending     = pending;
    assign sb.StallCycles = stall_cycles;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus random traffic against a ready-time reference model.
module tb_reg_scoreboard;
    logic Clock = 1'b0;
    logic Reset = 1'b0;

    reg_scoreboard_if bus ();

    reg_scoreboard dut (
        .Clock (Clock),
        .Reset (Reset),
        .sb    (bus)
    );

    always #5 Clock = ~Clock;

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int exp_sc = 0;
    int ready_at [32];

    // Model: a register is readable from cycle ready_at[r] onward.
    function automatic int lat_of(input logic [1:0] c);
        return (c == 2'd0) ? 2 : (c == 2'd1) ? 2 : 4;
    endfunction

    function automatic int remaining(input int r);
        if (r == 0) return 0;
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    function automatic bit model_hazard();
        bit h = 1'b0;
        if (bus.ID_UsesRs && remaining(int'(bus.ID_rs)) > 0) h = 1'b1;
        if (bus.ID_UsesRt && remaining(int'(bus.ID_rt)) > 0) h = 1'b1;
        if (bus.ID_WriteEn && bus.ID_rDest != 5'd0 &&
            remaining(int'(bus.ID_rDest)) > lat_of(bus.ID_Class)) h = 1'b1;
        return h;
    endfunction

    function automatic bit exp_stall();
        return bus.ID_Valid && model_hazard() && !bus.Flush;
    endfunction

    function automatic bit exp_issue();
        return bus.ID_Valid && !model_hazard() && !bus.Flush;
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = (remaining(r) > 0);
        return p;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        exp_sc = 0;
    endfunction

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input bit we, input int rd, input int cls);
        bus.ID_Valid   = v;
        bus.ID_rs      = 5'(rs);
        bus.ID_rt      = 5'(rt);
        bus.ID_UsesRs  = urs;
        bus.ID_UsesRt  = urt;
        bus.ID_WriteEn = we;
        bus.ID_rDest   = 5'(rd);
        bus.ID_Class   = 2'(cls);
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.Flush = 1'b0;
    endtask

    // Advance one clock, applying the model's view of this cycle's decision.
    task automatic tick();
        bit s, i;
        int l, rd;
        s  = exp_stall();
        i  = exp_issue();
        l  = lat_of(bus.ID_Class);
        rd = int'(bus.ID_rDest);
        @(posedge Clock);
        if (Reset) begin
            if (i && bus.ID_WriteEn && rd != 0) ready_at[rd] = cyc + 1 + l;
            if (s) exp_sc++;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        Reset = 1'b0;
        set_id(1, 3, 4, 1, 1, 1, 3, 2);
        bus.Flush = 1'b0;
        @(negedge Clock);
        total++; if (bus.Stall_PC !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.Stall_PC); end
        total++; if (bus.Issue !== 1'b1) begin bad++; $display("FAIL reset_issue got=%b want=1", bus.Issue); end
        total++; if (bus.Pending !== 32'h0) begin bad++; $display("FAIL reset_pending got=%h want=0", bus.Pending); end
        total++; if (bus.StallCycles !== 32'h0) begin bad++; $display("FAIL reset_stallcycles got=%0d want=0", bus.StallCycles); end
        tick();
        idle();
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_alu_raw();
        int stalls = 0;
        bit s, i, done = 1'b0;
        set_id(1, 0, 0, 0, 0, 1, 3, 0);
        @(negedge Clock);
        total++; if (bus.Issue !== 1'b1) begin bad++; $display("FAIL alu_producer_issue got=%b want=1", bus.Issue); end
        tick();
        set_id(1, 3, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge Clock);
            s = exp_stall(); i = exp_issue();
            total++;
            if ({bus.Stall_PC, bus.Stall_ID, bus.Stall_ID_EX, bus.Issue} !== {s, s, s, i}) begin
                bad++; $display("FAIL alu_raw_ctl cyc=%0d got=%b%b%b%b want=%b%b%b%b", cyc,
                    bus.Stall_PC, bus.Stall_ID, bus.Stall_ID_EX, bus.Issue, s, s, s, i);
            end
            total++; if (bus.Pending !== exp_pending()) begin bad++; $display("FAIL alu_raw_pending got=%h want=%h", bus.Pending, exp_pending()); end
            if (bus.Stall_ID === 1'b1) stalls++;
            done = i;
            tick();
        end
        total++; if (!done || stalls != 2) begin bad++; $display("FAIL alu_raw_stalls got=%0d want=2", stalls); end
        total++; if (bus.StallCycles !== 32'd2) begin bad++; $display("FAIL alu_raw_stallcycles got=%0d want=2", bus.StallCycles); end
        idle();
        tick();
    endtask

    task automatic test_mul_rt();
        int stalls = 0;
        bit s, i, done = 1'b0;
        set_id(1, 0, 0, 0, 0, 1, 5, 2);
        tick();
        set_id(1, 1, 5, 0, 1, 1, 6, 0);
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge Clock);
            s = exp_stall(); i = exp_issue();
            total++;
            if ({bus.Stall_ID, bus.Issue} !== {s, i}) begin
                bad++; $display("FAIL mul_rt_ctl cyc=%0d got=%b%b want=%b%b", cyc, bus.Stall_ID, bus.Issue, s, i);
            end
            if (bus.Stall_ID === 1'b1) stalls++;
            done = i;
            tick();
        end
        total++; if (!done || stalls != 4) begin bad++; $display("FAIL mul_rt_stalls got=%0d want=4", stalls); end
        idle();
        repeat (2) tick();
        set_id(1, 0, 0, 0, 0, 1, 5, 2);
        tick();
        set_id(1, 1, 5, 0, 0, 1, 6, 0);
        @(negedge Clock);
        total++;
        if ({bus.Stall_ID, bus.Issue} !== 2'b01) begin
            bad++; $display("FAIL mul_no_rt got=%b%b want=01", bus.Stall_ID, bus.Issue);
        end
        tick();
        idle();
        repeat (5) tick();
    endtask

    task automatic test_waw();
        int stalls = 0;
        bit i, done = 1'b0;
        set_id(1, 0, 0, 0, 0, 1, 7, 2);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 7, 0);
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge Clock);
            i = exp_issue();
            total++;
            if (bus.Issue !== i) begin bad++; $display("FAIL waw_issue cyc=%0d got=%b want=%b", cyc, bus.Issue, i); end
            if (bus.Stall_ID === 1'b1) stalls++;
            done = i;
            tick();
        end
        total++; if (!done || stalls != 2) begin bad++; $display("FAIL waw_stalls got=%0d want=2", stalls); end
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            total++;
            if (bus.Pending[7] !== (k < 2)) begin bad++; $display("FAIL waw_relatch k=%0d got=%b want=%b", k, bus.Pending[7], k < 2); end
            tick();
        end
    endtask

    task automatic test_flush();
        set_id(1, 0, 0, 0, 0, 1, 4, 0);
        tick();
        set_id(1, 4, 0, 1, 0, 0, 0, 0);
        @(negedge Clock);
        total++; if (bus.Stall_ID !== 1'b1) begin bad++; $display("FAIL flush_pre_stall got=%b want=1", bus.Stall_ID); end
        tick();
        bus.Flush = 1'b1;
        @(negedge Clock);
        total++;
        if ({bus.Stall_PC, bus.Stall_ID_EX, bus.Issue} !== 3'b000) begin
            bad++; $display("FAIL flush_ctl got=%b%b%b want=000", bus.Stall_PC, bus.Stall_ID_EX, bus.Issue);
        end
        total++; if (bus.Pending[4] !== 1'b1) begin bad++; $display("FAIL flush_keeps_cnt got=%b want=1", bus.Pending[4]); end
        tick();
        idle();
        @(negedge Clock);
        total++; if (bus.Pending[4] !== 1'b0) begin bad++; $display("FAIL flush_drain got=%b want=0", bus.Pending[4]); end
        tick();
    endtask

    task automatic test_reg0();
        set_id(1, 0, 0, 0, 0, 1, 0, 2);
        tick();
        set_id(1, 0, 0, 1, 1, 1, 0, 0);
        @(negedge Clock);
        total++;
        if ({bus.Stall_ID, bus.Issue} !== 2'b01) begin bad++; $display("FAIL reg0_ctl got=%b%b want=01", bus.Stall_ID, bus.Issue); end
        total++; if (bus.Pending !== 32'h0) begin bad++; $display("FAIL reg0_pending got=%h want=0", bus.Pending); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        set_id(1, 0, 0, 0, 0, 1, 9, 2);
        tick();
        set_id(1, 9, 0, 1, 0, 0, 0, 0);
        tick();
        @(negedge Clock);
        total++;
        if ({bus.Stall_PC, bus.Pending[9]} !== 2'b11 || remaining(9) != 3) begin
            bad++; $display("FAIL areset_pre got=%b%b want=11", bus.Stall_PC, bus.Pending[9]);
        end
        #2 Reset = 1'b0;
        #1;
        total++;
        if ({bus.Stall_PC, bus.Stall_ID, bus.Stall_ID_EX} !== 3'b000) begin
            bad++; $display("FAIL areset_stall_drop got=%b%b%b want=000", bus.Stall_PC, bus.Stall_ID, bus.Stall_ID_EX);
        end
        total++; if (bus.Pending !== 32'h0) begin bad++; $display("FAIL areset_pending got=%h want=0", bus.Pending); end
        model_clear();
        repeat (2) tick();
        Reset = 1'b1;
        @(negedge Clock);
        total++; if (bus.StallCycles !== 32'h0) begin bad++; $display("FAIL areset_stallcycles got=%0d want=0", bus.StallCycles); end
        total++; if (bus.Issue !== 1'b1) begin bad++; $display("FAIL areset_resume got=%b want=1", bus.Issue); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        bit s, i;
        for (int k = 0; k < 400; k++) begin
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3));
            bus.Flush = ($urandom_range(0, 7) == 0);
            @(negedge Clock);
            s = exp_stall(); i = exp_issue();
            total++;
            if ({bus.Stall_PC, bus.Stall_ID, bus.Stall_ID_EX, bus.Issue} !== {s, s, s, i}) begin
                bad++; $display("FAIL rand_ctl cyc=%0d got=%b%b%b%b want=%b%b%b%b", cyc,
                    bus.Stall_PC, bus.Stall_ID, bus.Stall_ID_EX, bus.Issue, s, s, s, i);
            end
            total++; if (bus.Pending !== exp_pending()) begin bad++; $display("FAIL rand_pending cyc=%0d got=%h want=%h", cyc, bus.Pending, exp_pending()); end
            total++; if (bus.StallCycles !== 32'(exp_sc)) begin bad++; $display("FAIL rand_stallcycles cyc=%0d got=%0d want=%0d", cyc, bus.StallCycles, exp_sc); end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        model_clear();
        test_reset();
        test_alu_raw();
        test_mul_rt();
        test_waw();
        test_flush();
        test_reg0();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register busy scoreboard for the 5-stage MIPS pipeline. It replaces per-stage rs/rt/rd comparison with countdown counters that track cycles until each destination register is readable in ID.
- Sits beside the ID stage: it consumes the decoded ID instruction and drives Stall_PC, Stall_ID and Stall_ID_EX.
- Supports variable-latency producers (ALU, load, multi-cycle mul); no forwarding is present.
- The register file writes in the first half-cycle and reads in the second.

Parameters:
- CNT_WIDTH, 3, width of each per-register countdown counter.
- ALU_LAT, 2, stall cycles owed to a consumer of an R-type/I-type ALU result.
- LOAD_LAT, 2, stall cycles owed to a consumer of a load result.
- MUL_LAT, 4, stall cycles owed to a consumer of a mul result (opcode 011100 class).

Ports:
- Clock  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- ID_Valid  in  1  ID holds a real instruction (0 for nop/bubble).
- ID_rs  in  5  source register rs.
- ID_rt  in  5  source register rt.
- ID_UsesRs  in  1  instruction reads rs.
- ID_UsesRt  in  1  instruction reads rt.
- ID_WriteEn  in  1  instruction writes a register.
- ID_rDest  in  5  selected destination register (rd or rt).
- ID_Class  in  2  0=ALU, 1=load, 2=mul, 3=reserved (treated as mul).
- Flush  in  1  taken branch/jump; squash ID this cycle.
- Stall_PC  out  1  hold PC.
- Stall_ID  out  1  hold IF/ID register.
- Stall_ID_EX  out  1  insert bubble into ID/EX.
- Issue  out  1  ID instruction advances to EX this cycle.
- Pending  out  32  bit r = 1 when cnt[r] != 0.
- StallCycles  out  32  count of cycles with Stall_ID asserted.

Behaviour:
- State:
  - cnt[1..31], CNT_WIDTH bits each; cnt[0] is hard-wired 0.
  - StallCycles, 32-bit.
- Reset (async, Reset=0): all cnt = 0 and StallCycles = 0.
  - Outputs during reset: Stall_* = 0, Pending = 0, Issue = ID_Valid & ~Flush.
- Lat = ALU_LAT / LOAD_LAT / MUL_LAT selected by ID_Class.
- Hazard is combinational from current state and ID inputs, asserted when any of:
  - RAW rs: ID_UsesRs & ID_rs != 0 & cnt[ID_rs] != 0.
  - RAW rt: ID_UsesRt & ID_rt != 0 & cnt[ID_rt] != 0.
  - WAW: ID_WriteEn & ID_rDest != 0 & cnt[ID_rDest] > Lat (older, longer write must not retire after the newer one).
- Stall = ID_Valid & Hazard & ~Flush.
  - Stall_PC = Stall_ID = Stall_ID_EX = Stall.
  - Flush has priority: no stall, no issue.
- Issue = ID_Valid & ~Hazard & ~Flush.
- Each rising edge, for every r:
  - If Issue & ID_WriteEn & ID_rDest == r & r != 0: cnt[r] <= Lat. Set wins over decrement.
  - Else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - Else hold 0.
- Timing: producer issues at edge t, so cnt = Lat in cycle t+1. A dependent in ID stalls exactly Lat cycles and issues in cycle t+1+Lat.
- Counters saturate at 0; never wrap below 0.
- Lat values above 2^CNT_WIDTH-1 are illegal parameterisations; elaboration must fail them via a width check.
- StallCycles += 1 on each edge where Stall = 1; wraps 0xFFFFFFFF -> 0.
- Writes to register 0 never mark busy; reads of register 0 never stall.
- Flush does not clear counters: producers already in EX/MEM/WB still retire.
- Reset asserted mid-stall: stall deasserts immediately (async); the pipeline resumes with an empty scoreboard.
- ID_Valid = 0: no stall, no issue, counters still decrement.

Test Plan:
- Reset=0 then release; ALU add $3 issues; next cycle ID reads $3 -> Stall_* = 1 for 2 cycles, Issue in 3rd cycle, Pending[3] 1→1→0, StallCycles = 2.
- Mul to $5 (MUL_LAT=4), then dependent reads $5 via rt -> 4 stall cycles. Same case with ID_UsesRt = 0 -> Issue immediately, 0 stalls.
- Mul to $7, then ALU write to $7 with no reads -> WAW stall until cnt[7] ≤ 2 (2 stall cycles), then Issue sets cnt[7] = 2.
- Dependent stalled on $4 with Flush = 1 in 2nd stall cycle -> Stall_* = 0, Issue = 0 that cycle; cnt[4] still decrements to 0.
- ID writes $0 and reads $0 back-to-back -> no stalls, Pending = 0.
- Reset asserted asynchronously mid-cycle while Stall = 1 (cnt[9] = 3) -> Stall_* drop without waiting for Clock; Pending = 0 and StallCycles = 0 after release.
